// File: rtl/smg_stopwatch_ctrl.sv
// Stopwatch controller for a two-digit seven-segment display: debounced start/pause and
// clear keys drive an IDLE/RUN/PAUSE FSM that counts BCD seconds 00..59 with rollover.
module smg_stopwatch_ctrl #(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int DB_CYCLES   = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_start_n,
    input  logic       key_clr_n,
    output logic [3:0] second_0,
    output logic [3:0] second_1,
    output logic       running,
    output logic       wrap_pulse
);

    localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    // Bit 0 is the start key, bit 1 the clear key.
    logic [1:0]           sync_1, sync_2;
    logic [1:0]           db_level;
    logic [1:0][DB_W-1:0] db_cnt;
    logic [1:0]           press;
    logic                 start_press, clr_press;

    state_t               state, state_nxt;
    logic [TICK_W-1:0]    presc;

    assign start_press = press[0];
    assign clr_press   = press[1];

    // NOTE: every clocked block uses non-blocking assignments so all flops sample
    // the values from before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 2'b11;
            sync_2 <= 2'b11;
        end else begin
            sync_1 <= {key_clr_n, key_start_n};
            sync_2 <= sync_1;
        end
    end

    // A level flips only after DB_CYCLES consecutive disagreeing samples; the press
    // pulse is registered on the flip itself, so it fires once per accepted fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level <= 2'b11;
            db_cnt   <= '0;
            press    <= 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                press[k] <= 1'b0;
                if (sync_2[k] != db_level[k]) begin
                    if (db_cnt[k] == DB_LAST) begin
                        db_level[k] <= sync_2[k];
                        db_cnt[k]   <= '0;
                        press[k]    <= db_level[k];
                    end else begin
                        db_cnt[k] <= db_cnt[k] + 1'b1;
                    end
                end else begin
                    db_cnt[k] <= '0;
                end
            end
        end
    end

    // NOTE: defaults are assigned first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        if (clr_press) begin
            state_nxt = IDLE;
        end else if (start_press) begin
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     state_nxt = PAUSE;
                PAUSE:   state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == RUN);
        end
    end

    // Clear outranks counting; the prescaler freezes in PAUSE and is zero in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            second_0   <= 4'd0;
            second_1   <= 4'd0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            if (clr_press) begin
                presc    <= '0;
                second_0 <= 4'd0;
                second_1 <= 4'd0;
            end else if (state == RUN) begin
                if (presc == TICK_LAST) begin
                    presc <= '0;
                    if (second_0 >= 4'd9) begin
                        second_0 <= 4'd0;
                        if (second_1 >= 4'd5) begin
                            second_1   <= 4'd0;
                            wrap_pulse <= 1'b1;
                        end else begin
                            second_1 <= second_1 + 4'd1;
                        end
                    end else begin
                        second_0 <= second_0 + 4'd1;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end else if (state == IDLE) begin
                presc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_smg_stopwatch_ctrl.sv
// Directed bench for smg_stopwatch_ctrl with TICK_CYCLES=10, DB_CYCLES=4: a vector table
// for debounce and basic start/clear, then hand-written multi-cycle corner sequences.
module tb_smg_stopwatch_ctrl;

    localparam int TICK = 10;
    localparam int DB   = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_start_n;
    logic       key_clr_n;
    logic [3:0] second_0;
    logic [3:0] second_1;
    logic       running;
    logic       wrap_pulse;

    int total = 0;
    int bad   = 0;

    // Independent monitor state: every count change must be +1 in BCD or a jump to 00.
    logic [7:0] seq_prev = 8'h00;
    int         seq_err  = 0;
    int         wrap_seen = 0;

    smg_stopwatch_ctrl #(.TICK_CYCLES(TICK), .DB_CYCLES(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_start_n(key_start_n),
        .key_clr_n  (key_clr_n),
        .second_0   (second_0),
        .second_1   (second_1),
        .running    (running),
        .wrap_pulse (wrap_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) r = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        else                r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    always @(negedge clk) begin
        if (second_0 > 4'd9 || second_1 > 4'd5) seq_err++;
        if (wrap_pulse) begin
            wrap_seen++;
            if (!(seq_prev == 8'h59 && {second_1, second_0} == 8'h00)) seq_err++;
        end
        if ({second_1, second_0} != seq_prev) begin
            if ({second_1, second_0} != 8'h00 && {second_1, second_0} != bcd_inc(seq_prev))
                seq_err++;
            seq_prev = {second_1, second_0};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_count(input logic [7:0] target, input int bound, input string name);
        bit found = 1'b0;
        for (int c = 0; c < bound && !found; c++) begin
            @(negedge clk);
            if ({second_1, second_0} == target) found = 1'b1;
        end
        check(name, 32'(found), 32'd1);
    endtask

    task automatic press_start(input int len);
        key_start_n = 1'b0;
        repeat (len) @(negedge clk);
        key_start_n = 1'b1;
    endtask

    typedef struct {
        logic       ks;
        logic       kc;
        int         n;
        bit         chk;
        logic       exp_run;
        logic [7:0] exp_cnt;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    initial begin
        int rise, got, t03, pfall, held, t04;
        bit found, dropped, rerise;

        // Times are negedges since the last key change; running rises 4..8 after a fall
        // and the first increment follows 10 later.
        vecs[0] = '{1'b1, 1'b1, 5,  1'b1, 1'b0, 8'h00};  // idle after reset
        vecs[1] = '{1'b0, 1'b1, 3,  1'b1, 1'b0, 8'h00};  // 3-cycle glitch
        vecs[2] = '{1'b1, 1'b1, 10, 1'b1, 1'b0, 8'h00};  // glitch rejected
        vecs[3] = '{1'b0, 1'b1, 2,  1'b0, 1'b0, 8'h00};  // bounce: 2 low
        vecs[4] = '{1'b1, 1'b1, 1,  1'b0, 1'b0, 8'h00};  //         1 high
        vecs[5] = '{1'b0, 1'b1, 6,  1'b0, 1'b0, 8'h00};  //         6 low
        vecs[6] = '{1'b1, 1'b1, 6,  1'b1, 1'b1, 8'h00};  // 12 after fall: running, 00
        vecs[7] = '{1'b1, 1'b1, 20, 1'b1, 1'b1, 8'h02};  // 32 after fall: 02
        vecs[8] = '{1'b1, 1'b0, 12, 1'b1, 1'b0, 8'h00};  // clear press
        vecs[9] = '{1'b1, 1'b1, 10, 1'b1, 1'b0, 8'h00};  // stays cleared

        rst_n = 1'b0;
        key_start_n = 1'b1;
        key_clr_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {24'd0, second_1, second_0}, 32'd0);
        check("reset_flags", {30'd0, running, wrap_pulse}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            key_start_n = vecs[i].ks;
            key_clr_n   = vecs[i].kc;
            repeat (vecs[i].n) @(negedge clk);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].exp_run));
                check($sformatf("vec%0d_count", i), {24'd0, second_1, second_0},
                      {24'd0, vecs[i].exp_cnt});
            end
        end

        // Start latency and first tick.
        rise = -1;
        got = -1;
        key_start_n = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 12) key_start_n = 1'b1;
            if (rise < 0 && running) rise = c;
            if (got < 0 && second_0 == 4'd1) got = c;
        end
        check("start_latency_in_window", 32'(rise >= DB && rise <= DB + 4), 32'd1);
        check("first_tick_after_run", 32'(got - rise), 32'(TICK));

        // Reset mid-run at 37.
        wait_count(8'h37, 600, "reach_37");
        rst_n = 1'b0;
        #1;
        check("midrun_reset_count", {24'd0, second_1, second_0}, 32'd0);
        check("midrun_reset_flags", {30'd0, running, wrap_pulse}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("post_reset_quiet", {22'd0, second_1, second_0, running, wrap_pulse}, 32'd0);

        // Rollover 59 -> 00.
        press_start(12);
        wait_count(8'h59, 700, "reach_59");
        found = 1'b0;
        for (int c = 0; c < 15 && !found; c++) begin
            @(negedge clk);
            if ({second_1, second_0} == 8'h00) found = 1'b1;
        end
        check("wrap_to_00", 32'(found), 32'd1);
        check("wrap_pulse_high", 32'(wrap_pulse), 32'd1);
        check("wrap_running", 32'(running), 32'd1);
        @(negedge clk);
        check("wrap_pulse_one_cycle", {23'd0, wrap_pulse, second_1, second_0}, 32'd0);

        // Pause around count 03 and resume from the held prescaler.
        wait_count(8'h02, 30, "reach_02");
        t03 = -1;
        pfall = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 9) key_start_n = 1'b0;
            if (c == 21) key_start_n = 1'b1;
            if (t03 < 0 && {second_1, second_0} == 8'h03) t03 = c;
            if (pfall < 0 && !running) pfall = c;
        end
        held = pfall - t03;
        check("tick_03_spacing", 32'(t03), 32'(TICK));
        check("pause_held_in_range", 32'(held >= 0 && held < TICK), 32'd1);
        found = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if ({second_1, second_0} != 8'h03 || running) found = 1'b0;
        end
        check("pause_holds_03", 32'(found), 32'd1);

        rise = -1;
        t04 = -1;
        key_start_n = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 12) key_start_n = 1'b1;
            if (rise < 0 && running) rise = c;
            if (t04 < 0 && {second_1, second_0} == 8'h04) t04 = c;
        end
        check("resume_seen", 32'(rise > 0 && t04 > 0), 32'd1);
        check("resume_remaining_cycles", 32'(t04 - rise), 32'(TICK - held));

        // Both keys together at count 12: clear wins.
        wait_count(8'h12, 200, "reach_12");
        dropped = 1'b0;
        rerise = 1'b0;
        key_start_n = 1'b0;
        key_clr_n = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 10) begin
                key_start_n = 1'b1;
                key_clr_n = 1'b1;
            end
            if (!running) dropped = 1'b1;
            else if (dropped) rerise = 1'b1;
        end
        check("simul_cleared", {23'd0, running, second_1, second_0}, 32'd0);
        check("simul_no_start", {30'd0, dropped, rerise}, 32'd2);

        // Key held low across reset is a fresh press after release.
        press_start(12);
        key_start_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rise = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rise < 0 && running) rise = c;
        end
        key_start_n = 1'b1;
        check("held_key_after_reset", 32'(rise >= DB && rise <= DB + 4), 32'd1);

        repeat (5) @(negedge clk);
        check("bcd_sequence_errors", 32'(seq_err), 32'd0);
        check("wrap_pulse_total", 32'(wrap_seen), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/smg_stopwatch_ctrl.md
SMG_STOPWATCH_CTRL -- requirements
Module: smg_stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_CYCLES, default 50_000_000, meaning clk cycles per 1 s count step.
REQ-002 The block SHALL have parameter DB_CYCLES, default 1_000_000, meaning consecutive stable cycles required to accept a key level (20 ms at 50 MHz).
REQ-003 The block SHALL have port clk  input  1  system clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port key_start_n  input  1  raw start/pause button, asynchronous, low = pressed.
REQ-006 The block SHALL have port key_clr_n  input  1  raw clear button, asynchronous, low = pressed.
REQ-007 The block SHALL have port second_0  output  4  BCD seconds units digit, range 0..9, for the downstream seven-segment display stage.
REQ-008 The block SHALL have port second_1  output  4  BCD seconds tens digit, range 0..5, for the downstream seven-segment display stage.
REQ-009 The block SHALL have port running  output  1  high while the FSM is in RUN.
REQ-010 The block SHALL have port wrap_pulse  output  1  one-cycle pulse when the count rolls over from 59 to 00.

Function
REQ-011 Each key input SHALL pass through a two-flop synchronizer before any other use.
REQ-012 Per key, a debounced level (reset value 1) SHALL change only after the synchronized input has differed from it for DB_CYCLES consecutive cycles; any return to the current level SHALL restart the count from 0.
REQ-013 A falling edge of a debounced level SHALL produce exactly one single-cycle internal press pulse; a held key and a key release SHALL produce no further pulse.
REQ-014 The FSM SHALL have states IDLE, RUN and PAUSE, and SHALL reset to IDLE.
REQ-015 A start press SHALL cause the transitions IDLE->RUN, RUN->PAUSE and PAUSE->RUN.
REQ-016 A clear press in any state SHALL force IDLE, set second_0=0 and second_1=0, and clear the prescaler.
REQ-017 When start and clear press pulses occur in the same cycle, clear SHALL win.
REQ-018 The state change SHALL occur no earlier than DB_CYCLES and no later than DB_CYCLES+4 cycles after the raw key falls and stays low.
REQ-019 The prescaler SHALL count 0..TICK_CYCLES-1 only in RUN, SHALL hold its value in PAUSE, and SHALL be 0 in IDLE.
REQ-020 On the edge where the prescaler equals TICK_CYCLES-1 in RUN, the prescaler SHALL return to 0 and the BCD count SHALL increment by one; the first increment SHALL therefore occur TICK_CYCLES cycles after entering RUN from IDLE.
REQ-021 BCD increment rule: second_0 9->0 with carry into second_1; second_1 5 with carry SHALL go to 0.
REQ-022 On the 59->00 edge, wrap_pulse SHALL be high for exactly the one cycle in which the outputs first read 00, and running SHALL remain 1.
REQ-023 On PAUSE->RUN, counting SHALL resume from the held prescaler value; the next increment SHALL follow after the remaining TICK_CYCLES-1-held+1 cycles.
REQ-024 second_0, second_1, running and wrap_pulse SHALL be driven directly from registers, with no combinational path from the key inputs.
REQ-025 second_0 SHALL never exceed 9 and second_1 SHALL never exceed 5.

Reset
REQ-026 While rst_n=0, regardless of clk: second_0=0, second_1=0, running=0, wrap_pulse=0, FSM=IDLE, prescaler=0, debounce counters=0, debounced levels=1, synchronizer flops=1.
REQ-027 Asserting rst_n mid-run SHALL abort all activity immediately; after release the block SHALL behave as after power-up, and a key already held low SHALL be treated as a new press once debounced.

Verification (TICK_CYCLES=10, DB_CYCLES=4)
REQ-028 Reset: assert rst_n=0 during RUN at count 37 -> outputs 0/0/0/0 immediately; no change after release without key activity.
REQ-029 Start: key_start_n low for 12 cycles -> running=1 within 4..8 cycles of the fall; second_0=1 exactly 10 cycles after running rises.
REQ-030 Glitch: key_start_n low for 3 cycles, then high -> running stays 0; bounce pattern 2 low/1 high/6 low -> exactly one start press.
REQ-031 Wrap: run to 59 -> the next tick gives 00, with wrap_pulse=1 for one cycle and running=1.
REQ-032 Pause/resume: pause with prescaler=6 at count 03, wait 50 cycles -> count stays 03; resume -> count 04 appears 4 cycles after running rises.
REQ-033 Simultaneous: in RUN at count 12, drive both keys low on the same cycle for 10 cycles -> IDLE, 00, running=0, with no start action.
